// File: rtl/mxint8_stim_pkg.sv
// Shared types and constants for the MXINT8 adder stimulus generator.
package mxint8_stim_pkg;

    localparam int unsigned LFSR_W   = 32;
    localparam int unsigned TXN_W    = 16;
    localparam int unsigned CORNER_W = 8;

    localparam logic [LFSR_W-1:0]   LFSR_MASK    = 32'h8020_0003;
    localparam logic [LFSR_W-1:0]   DEFAULT_SEED = 32'h0000_0001;
    localparam logic [CORNER_W-1:0] CORNER_ELEM  = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_OFFER = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [LFSR_W-1:0] lfsr_advance(input logic [LFSR_W-1:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
    endfunction

endpackage

// File: rtl/mxint8_stim_lfsr.sv
// 32-bit Galois LFSR with seed load; an all-zero seed is replaced by DEFAULT_SEED.
module mxint8_stim_lfsr
    import mxint8_stim_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [LFSR_W-1:0] seed,
    output logic [LFSR_W-1:0] state
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == '0) ? DEFAULT_SEED : seed;
        end else if (step) begin
            state <= lfsr_advance(state);
        end
    end

endmodule

// File: rtl/mxint8_add_stim_gen.sv
// Generates MXINT8 operand-block pairs from an LFSR and offers them with valid/ready.
// Optional: define MXINT8_STIM_CORNER_EN to force every 4th transaction's elements to 8'h80.
module mxint8_add_stim_gen
    import mxint8_stim_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE           = 32,
    parameter int unsigned SCALE_WIDTH          = 8,
    parameter int unsigned MXINT8_ELEMENT_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [15:0]                     i_num_txn,
    input  logic [31:0]                     i_seed,
    input  logic                            i_ready,
    output logic                            o_valid,
    output logic [SCALE_WIDTH-1:0]          o_scale_a,
    output logic [SCALE_WIDTH-1:0]          o_scale_b,
    output logic [MXINT8_ELEMENT_WIDTH-1:0] o_mxint8_elements_a [BLOCK_SIZE-1:0],
    output logic [MXINT8_ELEMENT_WIDTH-1:0] o_mxint8_elements_b [BLOCK_SIZE-1:0],
    output logic [15:0]                     o_txn_id,
    output logic                            o_busy,
    output logic                            o_done
);

    localparam int unsigned K_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(BLOCK_SIZE - 1);

    state_e                          state_q;
    state_e                          state_d;
    logic [K_W-1:0]                  k_q;
    logic [TXN_W-1:0]                num_txn_q;
    logic                            lfsr_load_c;
    logic                            lfsr_step_c;
    logic [LFSR_W-1:0]               lfsr_state;
    logic [LFSR_W-1:0]               lfsr_next_c;
    logic                            handshake_c;
    logic                            last_txn_c;
    logic [MXINT8_ELEMENT_WIDTH-1:0] elem_a_c;
    logic [MXINT8_ELEMENT_WIDTH-1:0] elem_b_c;

    mxint8_stim_lfsr u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load_c),
        .step  (lfsr_step_c),
        .seed  (i_seed),
        .state (lfsr_state)
    );

    assign lfsr_next_c = lfsr_advance(lfsr_state);
    assign handshake_c = o_valid && i_ready;
    assign last_txn_c  = (o_txn_id == (num_txn_q - 16'd1));

    // Element values written this FILL cycle.
    always_comb begin
        elem_a_c = MXINT8_ELEMENT_WIDTH'(lfsr_next_c[7:0]);
        elem_b_c = MXINT8_ELEMENT_WIDTH'(lfsr_next_c[15:8]);
`ifdef MXINT8_STIM_CORNER_EN
        if (o_txn_id[1:0] == 2'b11) begin
            elem_a_c = MXINT8_ELEMENT_WIDTH'(CORNER_ELEM);
            elem_b_c = MXINT8_ELEMENT_WIDTH'(CORNER_ELEM);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and LFSR control.
    always_comb begin
        state_d     = state_q;
        lfsr_load_c = 1'b0;
        lfsr_step_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    lfsr_load_c = 1'b1;
                    state_d     = (i_num_txn == 16'd0) ? ST_DONE : ST_FILL;
                end
            end
            ST_FILL: begin
                lfsr_step_c = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (handshake_c) begin
                    state_d = last_txn_c ? ST_DONE : ST_FILL;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q       <= '0;
            num_txn_q <= '0;
            o_txn_id  <= '0;
            o_scale_a <= '0;
            o_scale_b <= '0;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            for (int i = 0; i < int'(BLOCK_SIZE); i++) begin
                o_mxint8_elements_a[i] <= '0;
                o_mxint8_elements_b[i] <= '0;
            end
        end else begin
            o_valid <= (state_d == ST_OFFER);
            o_busy  <= (state_d == ST_FILL) || (state_d == ST_OFFER);
            o_done  <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        num_txn_q <= i_num_txn;
                        o_txn_id  <= '0;
                        k_q       <= '0;
                    end
                end
                ST_FILL: begin
                    o_mxint8_elements_a[k_q] <= elem_a_c;
                    o_mxint8_elements_b[k_q] <= elem_b_c;
                    if (k_q == '0) begin
                        o_scale_a <= SCALE_WIDTH'(lfsr_next_c[23:16]);
                        o_scale_b <= SCALE_WIDTH'(lfsr_next_c[31:24]);
                    end
                    if (k_q != K_LAST) begin
                        k_q <= k_q + K_W'(1);
                    end
                end
                ST_OFFER: begin
                    if (handshake_c && !last_txn_c) begin
                        o_txn_id <= o_txn_id + 16'd1;
                        k_q      <= '0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mxint8_add_stim_gen.sv
// Directed self-checking bench for mxint8_add_stim_gen.
module tb_mxint8_add_stim_gen;

    localparam int unsigned BS = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_start;
    logic [15:0] i_num_txn;
    logic [31:0] i_seed;
    logic        i_ready;
    logic        o_valid;
    logic [7:0]  o_scale_a;
    logic [7:0]  o_scale_b;
    logic [7:0]  ea [BS-1:0];
    logic [7:0]  eb [BS-1:0];
    logic [15:0] o_txn_id;
    logic        o_busy;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_lfsr;
    logic [7:0]  exp_a [BS];
    logic [7:0]  exp_b [BS];
    logic [7:0]  exp_sa;
    logic [7:0]  exp_sb;

    mxint8_add_stim_gen #(
        .BLOCK_SIZE           (BS),
        .SCALE_WIDTH          (8),
        .MXINT8_ELEMENT_WIDTH (8)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .i_start             (i_start),
        .i_num_txn           (i_num_txn),
        .i_seed              (i_seed),
        .i_ready             (i_ready),
        .o_valid             (o_valid),
        .o_scale_a           (o_scale_a),
        .o_scale_b           (o_scale_b),
        .o_mxint8_elements_a (ea),
        .o_mxint8_elements_b (eb),
        .o_txn_id            (o_txn_id),
        .o_busy              (o_busy),
        .o_done              (o_done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_nx(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic model_seed(input logic [31:0] seed);
        m_lfsr = (seed == 32'h0) ? 32'h1 : seed;
    endtask

    task automatic model_block(input bit corner);
        for (int i = 0; i < int'(BS); i++) begin
            m_lfsr   = lfsr_nx(m_lfsr);
            exp_a[i] = corner ? 8'h80 : m_lfsr[7:0];
            exp_b[i] = corner ? 8'h80 : m_lfsr[15:8];
            if (i == 0) begin
                exp_sa = m_lfsr[23:16];
                exp_sb = m_lfsr[31:24];
            end
        end
    endtask

    function automatic int block_diffs();
        int n = 0;
        for (int i = 0; i < int'(BS); i++) begin
            if (ea[i] !== exp_a[i]) n++;
            if (eb[i] !== exp_b[i]) n++;
        end
        if (o_scale_a !== exp_sa) n++;
        if (o_scale_b !== exp_sb) n++;
        return n;
    endfunction

    // Presents a one-cycle start; returns at the first sample after it is taken.
    task automatic start_run(input logic [31:0] seed, input logic [15:0] num);
        @(negedge clk);
        i_seed    = seed;
        i_num_txn = num;
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
    endtask

    task automatic test_reset();
        int nz = 0;
        rst_n = 1'b0; i_start = 1'b0; i_num_txn = '0; i_seed = '0; i_ready = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < int'(BS); i++) if (ea[i] !== 8'h0 || eb[i] !== 8'h0) nz++;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_txn_id !== 16'h0 ||
            o_scale_a !== 8'h0 || o_scale_b !== 8'h0 || nz != 0) begin
            errors++;
            $display("FAIL reset_state: valid=%b busy=%b done=%b txn=%h sa=%h sb=%h nonzero=%0d, want all 0",
                     o_valid, o_busy, o_done, o_txn_id, o_scale_a, o_scale_b, nz);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_txn();
        int lat;
        int done_cnt = 0;
        int done_at = 0;
        model_seed(32'h1);
        model_block(1'b0);
        i_ready = 1'b1;
        start_run(32'h1, 16'd1);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++; $display("FAIL busy_in_fill: busy=%b want 1", o_busy);
        end
        lat = 1;
        while (!o_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (o_valid !== 1'b1 || lat != 33) begin
            errors++; $display("FAIL single_latency: valid=%b cycle=%0d want valid at 33", o_valid, lat);
        end
        checks++;
        if (ea[0] !== 8'h03 || eb[0] !== 8'h00 || o_scale_a !== 8'h20 || o_scale_b !== 8'h80) begin
            errors++;
            $display("FAIL single_first: a0=%h b0=%h sa=%h sb=%h want 03 00 20 80", ea[0], eb[0], o_scale_a, o_scale_b);
        end
        checks++;
        if (ea[1] !== 8'h02 || ea[2] !== 8'h01 || ea[3] !== 8'h03 ||
            eb[1] !== 8'h00 || eb[2] !== 8'h00 || eb[3] !== 8'h00) begin
            errors++;
            $display("FAIL single_elems13: a=%h %h %h b=%h %h %h want 02 01 03 00 00 00",
                     ea[1], ea[2], ea[3], eb[1], eb[2], eb[3]);
        end
        checks++;
        if (block_diffs() != 0) begin
            errors++; $display("FAIL single_block: %0d diffs want 0", block_diffs());
        end
        @(negedge clk);
        checks++;
        if (o_valid !== 1'b0) begin
            errors++; $display("FAIL single_valid_drop: valid=%b want 0", o_valid);
        end
        for (int c = 35; c < 43; c++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
        end
        checks++;
        if (done_cnt != 1 || done_at != 35) begin
            errors++; $display("FAIL single_done: pulses=%0d at=%0d want 1 at 35", done_cnt, done_at);
        end
        i_ready = 1'b0;
    endtask

    task automatic test_stall();
        int lat;
        bit unstable = 1'b0;
        logic [7:0] sa, sb, a5, b31;
        logic [15:0] tid;
        int snap_diffs;
        model_seed(32'h1234_5678);
        model_block(1'b0);
        i_ready = 1'b0;
        start_run(32'h1234_5678, 16'd2);
        lat = 1;
        while (!o_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (o_valid !== 1'b1 || lat != 33 || block_diffs() != 0 || o_txn_id !== 16'd0) begin
            errors++;
            $display("FAIL stall_txn0: valid=%b cycle=%0d diffs=%0d txn=%0d want 1 33 0 0",
                     o_valid, lat, block_diffs(), o_txn_id);
        end
        sa = o_scale_a; sb = o_scale_b; a5 = ea[5]; b31 = eb[31]; tid = o_txn_id;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            snap_diffs = block_diffs();
            if (o_valid !== 1'b1 || o_scale_a !== sa || o_scale_b !== sb || ea[5] !== a5 ||
                eb[31] !== b31 || o_txn_id !== tid || snap_diffs != 0) unstable = 1'b1;
        end
        checks++;
        if (unstable) begin
            errors++; $display("FAIL stall_hold: outputs moved while stalled, valid=%b want stable", o_valid);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_txn_id !== 16'd1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL stall_advance: valid=%b txn=%0d busy=%b want 0 1 1", o_valid, o_txn_id, o_busy);
        end
        model_block(1'b0);
        lat = 1;
        while (!o_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (o_valid !== 1'b1 || lat != 33 || block_diffs() != 0 || o_txn_id !== 16'd1) begin
            errors++;
            $display("FAIL stall_txn1: valid=%b cycle=%0d diffs=%0d txn=%0d want 1 33 0 1",
                     o_valid, lat, block_diffs(), o_txn_id);
        end
        i_ready = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (o_done !== 1'b1 || o_valid !== 1'b0) begin
            errors++; $display("FAIL stall_done: done=%b valid=%b want 1 0", o_done, o_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_zero_txn();
        bit saw_valid = 1'b0;
        logic d1, d2, d3, b1;
        start_run(32'hDEAD_BEEF, 16'd0);
        d1 = o_done; b1 = o_busy;
        if (o_valid) saw_valid = 1'b1;
        @(negedge clk);
        d2 = o_done;
        if (o_valid) saw_valid = 1'b1;
        @(negedge clk);
        d3 = o_done;
        for (int c = 0; c < 40; c++) begin
            if (o_valid) saw_valid = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (d1 !== 1'b0 || d2 !== 1'b1 || d3 !== 1'b0 || b1 !== 1'b0 || saw_valid) begin
            errors++;
            $display("FAIL zero_txn: done c1/c2/c3=%b%b%b busy=%b valid_seen=%b want 010 0 0",
                     d1, d2, d3, b1, saw_valid);
        end
    endtask

    task automatic test_reset_mid_fill();
        int nz = 0;
        int lat;
        model_seed(32'h1);
        model_block(1'b0);
        i_ready = 1'b0;
        start_run(32'h1, 16'd1);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < int'(BS); i++) if (ea[i] !== 8'h0 || eb[i] !== 8'h0) nz++;
        checks++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_txn_id !== 16'h0 ||
            o_scale_a !== 8'h0 || o_scale_b !== 8'h0 || nz != 0) begin
            errors++;
            $display("FAIL async_reset: valid=%b busy=%b done=%b sa=%h sb=%h nonzero=%0d want all 0",
                     o_valid, o_busy, o_done, o_scale_a, o_scale_b, nz);
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_ready = 1'b1;
        start_run(32'h1, 16'd1);
        lat = 1;
        while (!o_valid && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (o_valid !== 1'b1 || lat != 33 || ea[0] !== 8'h03 || eb[0] !== 8'h00 ||
            o_scale_a !== 8'h20 || o_scale_b !== 8'h80 || block_diffs() != 0) begin
            errors++;
            $display("FAIL rerun_after_reset: cycle=%0d a0=%h b0=%h sa=%h sb=%h diffs=%0d want 33 03 00 20 80 0",
                     lat, ea[0], eb[0], o_scale_a, o_scale_b, block_diffs());
        end
        repeat (4) @(negedge clk);
        i_ready = 1'b0;
    endtask

    // Runs num transactions with i_ready=1; optionally holds i_start high until the last offer.
    task automatic run_multi(input string tag, input logic [31:0] seed, input int num, input bit hold_start);
        int ids [$];
        int diffs = 0;
        int dones = 0;
        bit mono = 1'b1;
        bit corner;
        model_seed(seed);
        i_ready = 1'b1;
        @(negedge clk);
        i_seed    = seed;
        i_num_txn = 16'(num);
        i_start   = 1'b1;
        @(negedge clk);
        if (!hold_start) i_start = 1'b0;
        for (int c = 0; c < 40 * num + 20; c++) begin
            if (o_valid === 1'b1) begin
                corner = 1'b0;
`ifdef MXINT8_STIM_CORNER_EN
                corner = (o_txn_id[1:0] == 2'b11);
`endif
                model_block(corner);
                diffs += block_diffs();
                if (ids.size() > 0 && int'(o_txn_id) != ids[ids.size()-1] + 1) mono = 1'b0;
                ids.push_back(int'(o_txn_id));
                if (ids.size() == num) i_start = 1'b0;
            end
            if (o_done === 1'b1) dones++;
            @(negedge clk);
        end
        i_start = 1'b0;
        i_ready = 1'b0;
        checks++;
        if (ids.size() != num || !mono || ids[0] != 0 || diffs != 0 || dones != 1) begin
            errors++;
            $display("FAIL %s: offers=%0d mono=%b first=%0d diffs=%0d dones=%0d want %0d 1 0 0 1",
                     tag, ids.size(), mono, (ids.size() > 0) ? ids[0] : -1, diffs, dones, num);
        end
    endtask

    task automatic test_start_while_busy();
        run_multi("start_while_busy", 32'h0, 3, 1'b1);
    endtask

    task automatic test_four_txn();
        run_multi("four_txn", 32'h1, 4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_txn();
        test_stall();
        test_zero_txn();
        test_reset_mid_fill();
        test_start_while_busy();
        test_four_txn();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
